// File: rtl/scarv_axi_mem_arbiter.sv
// rtl/scarv_axi_mem_arbiter.sv - multi-port SRAM-style requester to AXI4-lite master arbiter
module scarv_axi_mem_arbiter #(
    parameter int NPORTS   = 2,
    parameter int ARB_MODE = 1,
    parameter int GW       = 3
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic [NPORTS-1:0]      req_valid,
    input  logic [NPORTS-1:0]      req_instr,
    input  logic [32*NPORTS-1:0]   req_addr,
    input  logic [32*NPORTS-1:0]   req_wdata,
    input  logic [4*NPORTS-1:0]    req_wstrb,
    output logic [NPORTS-1:0]      req_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   busy,
    output logic [GW-1:0]          grant,
    output logic                   axi_awvalid,
    input  logic                   axi_awready,
    output logic [31:0]            axi_awaddr,
    output logic [2:0]             axi_awprot,
    output logic                   axi_wvalid,
    input  logic                   axi_wready,
    output logic [31:0]            axi_wdata,
    output logic [3:0]             axi_wstrb,
    input  logic                   axi_bvalid,
    output logic                   axi_bready,
    output logic                   axi_arvalid,
    input  logic                   axi_arready,
    output logic [31:0]            axi_araddr,
    output logic [2:0]             axi_arprot,
    input  logic                   axi_rvalid,
    output logic                   axi_rready,
    input  logic [31:0]            axi_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_ACK} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      r_rr_ptr;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic [3:0]         r_wstrb;
    logic               r_instr;
    logic               r_aw_done;
    logic               r_w_done;
    logic               r_ar_done;

    logic [2*NPORTS-1:0] w_req_dbl;
    logic [NPORTS-1:0]   w_req_rot;
    logic [GW-1:0]       w_base;
    logic [GW:0]         w_sum;
    logic [GW-1:0]       w_win;
    logic                w_any;
    logic [31:0]         w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic [3:0]          w_sel_wstrb;
    logic                w_sel_instr;

    // Rotate the request vector so the search always starts at bit 0;
    // fixed priority simply uses a base of zero.
    assign w_base    = (ARB_MODE == 1) ? r_rr_ptr : '0;
    assign w_req_dbl = {req_valid, req_valid};
    assign w_req_rot = NPORTS'(w_req_dbl >> w_base);

    // Winner search: lowest set bit of the rotated vector, mapped back to a port index.
    always_comb begin
        w_any = 1'b0;
        w_sum = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_any = 1'b1;
                w_sum = {1'b0, w_base} + (GW+1)'(i);
            end
        end
        if (w_sum >= (GW+1)'(NPORTS)) begin
            w_sum = w_sum - (GW+1)'(NPORTS);
        end
        w_win = w_sum[GW-1:0];
    end

    // Select the winning port's request fields for latching.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        w_sel_instr = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (w_win == GW'(i)) begin
                w_sel_addr  = req_addr[32*i +: 32];
                w_sel_wdata = req_wdata[32*i +: 32];
                w_sel_wstrb = req_wstrb[4*i +: 4];
                w_sel_instr = req_instr[i];
            end
        end
    end

    // Next-state and handshake outputs; everything is decoded from registered state.
    always_comb begin
        w_state_nxt = r_state;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        busy        = (r_state != S_IDLE);
        for (int i = 0; i < NPORTS; i++) begin
            req_ready[i] = (r_state == S_ACK) && (r_grant == GW'(i));
        end
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = (w_sel_wstrb != 4'b0000) ? S_WR : S_RD;
                end
            end
            S_WR: begin
                axi_awvalid = !r_aw_done;
                axi_wvalid  = !r_w_done;
                axi_bready  = r_aw_done && r_w_done;
                if (axi_bvalid && axi_bready) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_RD: begin
                axi_arvalid = !r_ar_done;
                axi_rready  = r_ar_done;
                if (axi_rvalid && axi_rready) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus request latch, handshake flags, read capture and rr pointer.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_wstrb   <= '0;
            r_instr   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_ar_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_win;
                        r_addr    <= w_sel_addr;
                        r_wdata   <= w_sel_wdata;
                        r_wstrb   <= w_sel_wstrb;
                        r_instr   <= w_sel_instr;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_ar_done <= 1'b0;
                    end
                end
                S_WR: begin
                    if (axi_awvalid && axi_awready) begin
                        r_aw_done <= 1'b1;
                    end
                    if (axi_wvalid && axi_wready) begin
                        r_w_done <= 1'b1;
                    end
                end
                S_RD: begin
                    if (axi_arvalid && axi_arready) begin
                        r_ar_done <= 1'b1;
                    end
                    if (axi_rvalid && axi_rready) begin
                        r_rdata <= axi_rdata;
                    end
                end
                S_ACK: begin
                    r_rr_ptr <= (r_grant == GW'(NPORTS - 1)) ? '0 : r_grant + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_rdata  = r_rdata;
    assign grant      = r_grant;
    assign axi_awaddr = {r_addr[31:2], 2'b00};
    assign axi_araddr = {r_addr[31:2], 2'b00};
    assign axi_awprot = 3'b000;
    assign axi_arprot = {r_instr, 2'b00};
    assign axi_wdata  = r_wdata;
    assign axi_wstrb  = r_wstrb;

endmodule

// File: tb/tb_scarv_axi_mem_arbiter.sv
// tb/tb_scarv_axi_mem_arbiter.sv - randomized self-checking bench for scarv_axi_mem_arbiter
module tb_scarv_axi_mem_arbiter;

    localparam int NP = 3;
    localparam int GW = 3;

    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    always #5 g_clk = ~g_clk;

    logic [NP-1:0]    req_valid = '0;
    logic [NP-1:0]    req_instr = '0;
    logic [32*NP-1:0] req_addr  = '0;
    logic [32*NP-1:0] req_wdata = '0;
    logic [4*NP-1:0]  req_wstrb = '0;

    logic        axi_awready = 1'b0;
    logic        axi_wready  = 1'b0;
    logic        axi_bvalid  = 1'b0;
    logic        axi_arready = 1'b0;
    logic        axi_rvalid  = 1'b0;
    logic [31:0] axi_rdata   = '0;

    logic [NP-1:0] req_ready;
    logic [31:0]   rsp_rdata;
    logic          busy;
    logic [GW-1:0] grant;
    logic          axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
    logic [31:0]   axi_awaddr, axi_wdata, axi_araddr;
    logic [2:0]    axi_awprot, axi_arprot;
    logic [3:0]    axi_wstrb;

    logic [NP-1:0] fp_req_ready;
    logic [31:0]   fp_rsp_rdata;
    logic          fp_busy;
    logic [GW-1:0] fp_grant;
    logic          fp_awvalid, fp_wvalid, fp_bready, fp_arvalid, fp_rready;
    logic [31:0]   fp_awaddr, fp_wdata, fp_araddr;
    logic [2:0]    fp_awprot, fp_arprot;
    logic [3:0]    fp_wstrb;

    scarv_axi_mem_arbiter #(.NPORTS(NP), .ARB_MODE(1), .GW(GW)) u_dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .req_valid(req_valid), .req_instr(req_instr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_rdata(rsp_rdata), .busy(busy), .grant(grant),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata)
    );

    scarv_axi_mem_arbiter #(.NPORTS(NP), .ARB_MODE(0), .GW(GW)) u_fp (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .req_valid(req_valid), .req_instr(req_instr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(fp_req_ready),
        .rsp_rdata(fp_rsp_rdata), .busy(fp_busy), .grant(fp_grant),
        .axi_awvalid(fp_awvalid), .axi_awready(axi_awready), .axi_awaddr(fp_awaddr), .axi_awprot(fp_awprot),
        .axi_wvalid(fp_wvalid), .axi_wready(axi_wready), .axi_wdata(fp_wdata), .axi_wstrb(fp_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(fp_bready),
        .axi_arvalid(fp_arvalid), .axi_arready(axi_arready), .axi_araddr(fp_araddr), .axi_arprot(fp_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(fp_rready), .axi_rdata(axi_rdata)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending requests per port, rr pointer, last read data.
    logic [NP-1:0] p_valid = '0;
    logic [31:0]   p_addr  [NP];
    logic [31:0]   p_wdata [NP];
    logic [3:0]    p_wstrb [NP];
    logic          p_instr [NP];
    int            m_ptr  = 0;
    logic [31:0]   m_last = '0;

    function automatic int pick(input bit rr);
        for (int k = 0; k < NP; k++) begin
            int p;
            p = rr ? (m_ptr + k) % NP : k;
            if (p_valid[p]) return p;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NP; i++) begin
            req_valid[i]         = p_valid[i];
            req_instr[i]         = p_instr[i];
            req_addr[32*i +: 32] = p_addr[i];
            req_wdata[32*i +: 32] = p_wdata[i];
            req_wstrb[4*i +: 4]  = p_wstrb[i];
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic ins);
        p_valid[i] = 1'b1;
        p_addr[i]  = a;
        p_wdata[i] = d;
        p_wstrb[i] = s;
        p_instr[i] = ins;
    endtask

    task automatic slave_idle();
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rdata   = '0;
    endtask

    task automatic do_reset();
        slave_idle();
        p_valid = '0;
        drive_reqs();
        g_resetn = 1'b0;
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
        m_ptr  = 0;
        m_last = '0;
        @(negedge g_clk);
    endtask

    // One transaction, entered and left at a negedge with the DUT in IDLE.
    task automatic run_txn(input int da, input int dw, input int db, input int dr,
                           input bit drop, input bit keep, input bit fp_chk,
                           input logic [31:0] rd_val);
        int win, fp_win, k, aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit aw_hs, w_hs, done, is_wr;
        logic [31:0] exp_addr;
        win    = pick(1'b1);
        fp_win = pick(1'b0);
        is_wr  = (p_wstrb[win] != 4'h0);
        exp_addr = {p_addr[win][31:2], 2'b00};
        k = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_hs = 1'b0; w_hs = 1'b0; done = 1'b0;
        drive_reqs();
        chk("idle_busy", busy, 0);
        while (!done && k < 60) begin
            @(negedge g_clk);
            k++;
            chk("busy", busy, 1);
            chk("one_txn", axi_arvalid & (axi_awvalid | axi_wvalid), 0);
            if (k == 1) begin
                chk("grant", grant, win);
                if (fp_chk) chk("fp_grant", fp_grant, fp_win);
                if (drop) begin
                    p_valid[win] = 1'b0;
                    drive_reqs();
                end
            end
            if (axi_arvalid) begin
                chk("araddr", axi_araddr, exp_addr);
                chk("arprot", axi_arprot, {p_instr[win], 2'b00});
            end
            if (axi_awvalid) begin
                chk("awaddr", axi_awaddr, exp_addr);
                chk("awprot", axi_awprot, 0);
            end
            if (axi_wvalid) begin
                chk("wdata", axi_wdata, p_wdata[win]);
                chk("wstrb", axi_wstrb, p_wstrb[win]);
            end
            if (aw_hs) chk("aw_dropped", axi_awvalid, 0);
            if (w_hs)  chk("w_dropped", axi_wvalid, 0);
            if (axi_bready) chk("bready_both", {aw_hs, w_hs}, 2'b11);
            if (req_ready != '0) begin
                chk("ready_port", req_ready, 32'(1) << win);
                if (!is_wr) m_last = rd_val;
                chk("rsp_rdata", rsp_rdata, m_last);
                if (da == 0 && dw == 0 && db == 0 && dr == 0) chk("latency", k, 3);
                done = 1'b1;
            end
            if (done) begin
                slave_idle();
            end else begin
                axi_awready = 1'b0;
                if (axi_awvalid) begin
                    if (aw_cnt >= da) begin axi_awready = 1'b1; aw_hs = 1'b1; end
                    else aw_cnt++;
                end
                axi_wready = 1'b0;
                if (axi_wvalid) begin
                    if (w_cnt >= dw) begin axi_wready = 1'b1; w_hs = 1'b1; end
                    else w_cnt++;
                end
                axi_bvalid = 1'b0;
                if (axi_bready) begin
                    if (b_cnt >= db) axi_bvalid = 1'b1;
                    else b_cnt++;
                end
                axi_arready = 1'b0;
                if (axi_arvalid) begin
                    if (ar_cnt >= da) axi_arready = 1'b1;
                    else ar_cnt++;
                end
                axi_rvalid = 1'b0;
                axi_rdata  = '0;
                if (axi_rready) begin
                    if (r_cnt >= dr) begin axi_rvalid = 1'b1; axi_rdata = rd_val; end
                    else r_cnt++;
                end
            end
        end
        chk("txn_done", {31'b0, done}, 1);
        if (!done) begin
            do_reset();
        end else begin
            if (!keep) p_valid[win] = 1'b0;
            m_ptr = (win + 1) % NP;
            drive_reqs();
            @(negedge g_clk);
            chk("ready_once", req_ready, 0);
            chk("back_idle", busy, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NP; i++) begin
            p_addr[i] = '0; p_wdata[i] = '0; p_wstrb[i] = '0; p_instr[i] = 1'b0;
        end
        drive_reqs();
        @(negedge g_clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 0);
        chk("rst_ready", req_ready, 0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(negedge g_clk);

        // single zero-wait read from port 0
        set_req(0, 32'h0000_1000, 32'h0, 4'h0, 1'b0);
        run_txn(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("read_data", rsp_rdata, 32'hDEAD_BEEF);

        // write with W lagging AW by two cycles
        set_req(1, 32'h0000_2004, 32'h55AA_00FF, 4'b0011, 1'b0);
        run_txn(0, 2, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);

        // misaligned instruction fetch
        set_req(2, 32'h0000_1003, 32'h0, 4'h0, 1'b1);
        run_txn(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h1234_5678);

        // requester drops valid after grant
        set_req(0, 32'h0000_3000, 32'h0, 4'h0, 1'b0);
        run_txn(1, 0, 0, 1, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);

        // reset while a read is waiting for arready
        set_req(1, 32'h0000_4000, 32'h0, 4'h0, 1'b0);
        drive_reqs();
        @(negedge g_clk);
        chk("rst_mid_arvalid", axi_arvalid, 1);
        #2 g_resetn = 1'b0;
        #1;
        chk("rst_mid_arvalid_low", axi_arvalid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_grant", grant, 0);
        chk("rst_mid_rdata", rsp_rdata, 0);
        chk("rst_mid_ready", req_ready, 0);
        p_valid = '0;
        drive_reqs();
        @(negedge g_clk);
        g_resetn = 1'b1;
        m_ptr  = 0;
        m_last = '0;
        @(negedge g_clk);
        chk("rst_mid_idle", busy, 0);
        set_req(2, 32'h0000_5008, 32'h0, 4'h0, 1'b0);
        run_txn(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'hA5A5_5A5A);

        // all ports requesting continuously: rr vs fixed priority
        do_reset();
        for (int i = 0; i < NP; i++) set_req(i, 32'h100 * (i + 1), 32'h0, 4'h0, 1'b0);
        for (int j = 0; j < 4; j++) run_txn(0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h1000 + j);
        p_valid = '0;
        drive_reqs();
        @(negedge g_clk);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NP; i++) begin
                if (!p_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, $urandom, $urandom,
                            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                            1'($urandom_range(0, 1)));
            end
            if (p_valid == '0)
                set_req($urandom_range(0, NP - 1), $urandom, $urandom, 4'h0, 1'b0);
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), ($urandom_range(0, 4) == 0), 1'b0, 1'b0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/scarv_axi_mem_arbiter.md
SCARV_AXI_MEM_ARBITER -- requirements
Module: scarv_axi_mem_arbiter

Interface
REQ-001 Parameter NPORTS, default 2, number of SRAM-style requester ports (legal 1..8).
REQ-002 Parameter ARB_MODE, default 1, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-003 Parameter GW, default 3, width of grant index output; SHALL be at least clog2(NPORTS) and at least 1.
REQ-004 g_clk  in  1  single clock; all state changes on rising edge.
REQ-005 g_resetn  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NPORTS  per-port request, held until matching req_ready.
REQ-007 req_instr  in  NPORTS  per-port instruction-fetch flag.
REQ-008 req_addr  in  32*NPORTS  per-port byte address; port i occupies bits [32i+31:32i].
REQ-009 req_wdata  in  32*NPORTS  per-port write data.
REQ-010 req_wstrb  in  4*NPORTS  per-port byte strobes; all-zero means read.
REQ-011 req_ready  out  NPORTS  one-cycle completion pulse to the granted port.
REQ-012 rsp_rdata  out  32  read data, shared by all ports, valid when any req_ready bit is 1.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 grant  out  GW  index of the port currently or last served.
REQ-015 AXI4-lite master: axi_awvalid/awready/awaddr[32]/awprot[3], axi_wvalid/wready/wdata[32]/wstrb[4], axi_bvalid/bready, axi_arvalid/arready/araddr[32]/arprot[3], axi_rvalid/rready/rdata[32]; directions per AXI master.

Function
REQ-016 FSM states: IDLE, WR, RD, ACK.
REQ-017 IDLE: if any req_valid is 1, latch the winner's index, addr, wdata and wstrb, then go to WR if wstrb != 0, else to RD; otherwise stay in IDLE.
REQ-018 Fixed priority: the winner is the lowest-index asserted req_valid.
REQ-019 Round robin: the winner is the first asserted req_valid at or above pointer rr_ptr, searching upward with wrap modulo NPORTS.
REQ-020 Round robin: rr_ptr = (grant+1) mod NPORTS on each ACK.
REQ-021 WR: axi_awvalid and axi_wvalid are driven independently; each is held until its own handshake and then dropped, tracked by flags aw_done and w_done.
REQ-022 WR: axi_bready = aw_done & w_done; on bvalid & bready, go to ACK; rsp_rdata is not updated.
REQ-023 Same-cycle AW and W handshakes are legal; the earliest possible exit from WR is the cycle after both handshakes complete.
REQ-024 RD: axi_arvalid is held until arready; after that handshake axi_rready = 1; on rvalid & rready, capture axi_rdata into rsp_rdata and go to ACK.
REQ-025 ACK: req_ready[grant] = 1 for exactly one cycle, then go to IDLE; no new grant is taken in ACK.
REQ-026 Latency with zero-wait slave: IDLE grant cycle 0; arvalid & arready cycle 1; rvalid cycle 2; req_ready cycle 3.
REQ-027 Latency for writes: identical to reads, with the AW/W handshakes in cycle 1 and B in cycle 2.
REQ-028 awaddr and araddr = latched address with bits [1:0] forced to 0.
REQ-029 awprot = 3'b000.
REQ-030 arprot = {req_instr[grant] latched, 2'b00}.
REQ-031 AXI address/data/strobe outputs are driven only from the latched request and are stable while the corresponding valid is high.
REQ-032 A requester dropping req_valid mid-transaction does not abort it: the AXI transaction completes and req_ready still pulses.
REQ-033 Simultaneous requests: exactly one port is served per transaction; the others wait, unaffected.
REQ-034 NPORTS = 1: the block acts as a plain SRAM-to-AXI adapter; rr_ptr stays at 0.
REQ-035 At most one AXI transaction is outstanding at any time.

Reset
REQ-036 g_resetn low forces immediately, without a clock edge: state = IDLE; all AXI valid/ready outputs = 0; req_ready = 0; rsp_rdata = 0; grant = 0; rr_ptr = 0; aw_done = w_done = 0.
REQ-037 Reset mid-transaction abandons the transaction; after release, the first cycle is IDLE with no pending grant.

Verification
REQ-038 Single read: port 0 reads 0x1000 from a zero-wait slave returning 0xDEADBEEF -> arvalid in cycle 1, req_ready[0] in cycle 3, rsp_rdata = 0xDEADBEEF.
REQ-039 Write with skew: port 1 writes 0x55AA00FF with wstrb 4'b0011; slave asserts wready 2 cycles after awready -> bready rises only after both handshakes, then req_ready[1] pulses once.
REQ-040 Round robin, NPORTS = 3, all valid continuously -> grant sequence 0, 1, 2, 0; with ARB_MODE = 0 -> grant 0 repeatedly.
REQ-041 Address alignment: request to 0x1003 -> araddr = 0x1000; req_instr = 1 -> arprot = 3'b100.
REQ-042 Reset mid-transaction: g_resetn low while in RD with arvalid high -> arvalid low in the same cycle, busy = 0; after release, a new request completes normally.
REQ-043 Valid drop: port 0 deasserts req_valid after the grant cycle -> the AXI read still completes and req_ready[0] pulses exactly once.
